d_hazard_npc: RTL and testbench

//  Decode-side partner of the fetch unit. Consumes IRD/PC4D and returns NPC, PCsrc, Branch,
//  RS_D_OUT and PauseF/PauseD to fetch. Holds the D/E register IRE/PC8E and shadow E/M hazard

---
 rtl/d_hazard_npc.sv | 211 +++++++++++++++++++++
 tb/tb_d_hazard_npc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/d_hazard_npc.sv
// Decode-stage hazard unit and next-PC logic: branch/jump redirect, Tuse/Tnew stall
// detection against shadow E/M state, and the D/E pipeline register. Optional MDU busy stall: MDU_STALL_EN.
module d_hazard_npc #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  input  logic [31:0] PC4D,
  input  logic [31:0] RS_D,
  input  logic [31:0] RT_D,
  output logic [31:0] NPC,
  output logic [1:0]  PCsrc,
  output logic        Branch,
  output logic [31:0] RS_D_OUT,
  output logic        PauseF,
  output logic        PauseD,
  output logic [31:0] IRE,
  output logic [31:0] PC8E
);

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic        w_rtype;
  logic        w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;

  assign w_op    = IRD[31:26];
  assign w_rs    = IRD[25:21];
  assign w_rt    = IRD[20:16];
  assign w_rd    = IRD[15:11];
  assign w_funct = IRD[5:0];
  assign w_imm   = IRD[15:0];
  assign w_rtype = (w_op == 6'h00);

  assign w_addu = w_rtype && (w_funct == 6'h21);
  assign w_subu = w_rtype && (w_funct == 6'h23);
  assign w_jr   = w_rtype && (w_funct == 6'h08);
  assign w_ori  = (w_op == 6'h0d);
  assign w_lui  = (w_op == 6'h0f);
  assign w_lw   = (w_op == 6'h23);
  assign w_sw   = (w_op == 6'h2b);
  assign w_beq  = (w_op == 6'h04);
  assign w_bne  = (w_op == 6'h05);
  assign w_j    = (w_op == 6'h02);
  assign w_jal  = (w_op == 6'h03);

  logic w_mult, w_div, w_mf, w_mt, w_md_op, w_md_stall, w_unused;

`ifdef MDU_STALL_EN
  localparam int MDU_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MDU_MAX + 1);

  logic [CW-1:0] r_md_cnt;
  logic          w_md_load;

  assign w_mult  = w_rtype && ((w_funct == 6'h18) || (w_funct == 6'h19));
  assign w_div   = w_rtype && ((w_funct == 6'h1a) || (w_funct == 6'h1b));
  assign w_mf    = w_rtype && ((w_funct == 6'h10) || (w_funct == 6'h12));
  assign w_mt    = w_rtype && ((w_funct == 6'h11) || (w_funct == 6'h13));
  assign w_md_op = w_mult || w_div || w_mf || w_mt;
  assign w_md_stall = w_md_op && (r_md_cnt != '0);
  assign w_unused   = ^IRD[10:6];
`else
  assign w_mult  = 1'b0;
  assign w_div   = 1'b0;
  assign w_mf    = 1'b0;
  assign w_mt    = 1'b0;
  assign w_md_op = 1'b0;
  assign w_md_stall = 1'b0;
  assign w_unused   = (^IRD[10:6]) ^ (MULT_CYC > DIV_CYC);
`endif

  // Source usage, Tuse, and the destination/Tnew this instruction carries into E
  logic       w_use_rs, w_use_rt;
  logic [1:0] w_tuse_rs, w_tuse_rt, w_tnew;
  logic [4:0] w_dst;

  always_comb begin
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_tuse_rs = 2'd0;
    w_tuse_rt = 2'd0;
    w_dst     = 5'd0;
    w_tnew    = 2'd0;
    if (w_beq || w_bne) begin
      w_use_rs = 1'b1;
      w_use_rt = 1'b1;
    end else if (w_jr) begin
      w_use_rs = 1'b1;
    end else if (w_addu || w_subu) begin
      w_use_rs  = 1'b1;
      w_use_rt  = 1'b1;
      w_tuse_rs = 2'd1;
      w_tuse_rt = 2'd1;
      w_dst     = w_rd;
      w_tnew    = 2'd1;
    end else if (w_ori) begin
      w_use_rs  = 1'b1;
      w_tuse_rs = 2'd1;
      w_dst     = w_rt;
      w_tnew    = 2'd1;
    end else if (w_lui) begin
      w_dst  = w_rt;
      w_tnew = 2'd1;
    end else if (w_lw) begin
      w_use_rs  = 1'b1;
      w_tuse_rs = 2'd1;
      w_dst     = w_rt;
      w_tnew    = 2'd2;
    end else if (w_sw) begin
      w_use_rs  = 1'b1;
      w_use_rt  = 1'b1;
      w_tuse_rs = 2'd1;
      w_tuse_rt = 2'd2;
    end else if (w_jal) begin
      w_dst  = 5'd31;
      w_tnew = 2'd0;
    end else if (w_mult || w_div) begin
      w_use_rs  = 1'b1;
      w_use_rt  = 1'b1;
      w_tuse_rs = 2'd1;
      w_tuse_rt = 2'd1;
    end else if (w_mt) begin
      w_use_rs  = 1'b1;
      w_tuse_rs = 2'd1;
    end else if (w_mf) begin
      w_dst  = w_rd;
      w_tnew = 2'd1;
    end
  end

  logic [4:0] r_a3_e, r_a3_m;
  logic [1:0] r_tnew_e, r_tnew_m;
  logic       w_hz_rs, w_hz_rt, w_stall;

  // $0 never matches: a zero source or zero destination cannot create a hazard
  assign w_hz_rs = w_use_rs && (w_rs != 5'd0) &&
                   (((w_rs == r_a3_e) && (w_tuse_rs < r_tnew_e)) ||
                    ((w_rs == r_a3_m) && (w_tuse_rs < r_tnew_m)));
  assign w_hz_rt = w_use_rt && (w_rt != 5'd0) &&
                   (((w_rt == r_a3_e) && (w_tuse_rt < r_tnew_e)) ||
                    ((w_rt == r_a3_m) && (w_tuse_rt < r_tnew_m)));
  assign w_stall = (w_hz_rs || w_hz_rt || w_md_stall) && !Reset;

  assign PauseF   = w_stall;
  assign PauseD   = w_stall;
  assign RS_D_OUT = RS_D;

  logic w_taken;
  assign w_taken = (w_beq && (RS_D == RT_D)) || (w_bne && (RS_D != RT_D));

  always_comb begin
    NPC    = 32'd0;
    PCsrc  = 2'd0;
    Branch = 1'b0;
    if (w_beq || w_bne)
      NPC = PC4D + {{14{w_imm[15]}}, w_imm, 2'b00};
    else if (w_j || w_jal)
      NPC = {PC4D[31:28], IRD[25:0], 2'b00};
    if (!w_stall) begin
      if (w_taken) begin
        PCsrc  = 2'd1;
        Branch = 1'b1;
      end else if (w_j || w_jal) begin
        PCsrc = 2'd1;
      end else if (w_jr) begin
        PCsrc = 2'd2;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IRE      <= 32'd0;
      PC8E     <= 32'd0;
      r_a3_e   <= 5'd0;
      r_tnew_e <= 2'd0;
      r_a3_m   <= 5'd0;
      r_tnew_m <= 2'd0;
    end else begin
      if (w_stall) begin
        IRE      <= 32'd0;
        r_a3_e   <= 5'd0;
        r_tnew_e <= 2'd0;
      end else begin
        IRE      <= IRD;
        PC8E     <= PC4D + 32'd4;
        r_a3_e   <= w_dst;
        r_tnew_e <= w_tnew;
      end
      r_a3_m   <= r_a3_e;
      r_tnew_m <= (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
    end
  end

`ifdef MDU_STALL_EN
  assign w_md_load = !w_stall && (w_mult || w_div);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_md_cnt <= '0;
    else if (w_md_load)
      r_md_cnt <= w_mult ? CW'(MULT_CYC) : CW'(DIV_CYC);
    else if (r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - CW'(1);
  end
`endif

endmodule

// File: tb/tb_d_hazard_npc.sv
// Directed bench for d_hazard_npc: a per-cycle vector table plus reset-mid-stall and MDU sequences.
module tb_d_hazard_npc;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IRD, PC4D, RS_D, RT_D;
  logic [31:0] NPC, RS_D_OUT, IRE, PC8E;
  logic [1:0]  PCsrc;
  logic        Branch, PauseF, PauseD;

  d_hazard_npc dut (
    .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC4D(PC4D), .RS_D(RS_D), .RT_D(RT_D),
    .NPC(NPC), .PCsrc(PCsrc), .Branch(Branch), .RS_D_OUT(RS_D_OUT),
    .PauseF(PauseF), .PauseD(PauseD), .IRE(IRE), .PC8E(PC8E)
  );

  always #5 Clk = ~Clk;

`ifdef MDU_STALL_EN
  localparam int EXP_MD_STALLS = 5;
`else
  localparam int EXP_MD_STALLS = 0;
`endif

  typedef struct {
    logic [31:0] ird, pc4d, rs, rt, npc;
    logic [1:0]  pcsrc;
    logic        br, pause;
    logic [31:0] ire, pc8e;
    logic        chk_pc8e;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int stalls;
    // ird, pc4d, rs, rt, npc, pcsrc, br, pause, ire(after edge), pc8e(after edge), chk_pc8e
    vq.push_back('{32'h00000000, 32'h3000, 0, 0, 32'h0, 2'd0, 0, 0, 32'h00000000, 32'h3004, 1});
    vq.push_back('{32'h8C010000, 32'h3004, 0, 0, 32'h0, 2'd0, 0, 0, 32'h8C010000, 32'h3008, 1});
    vq.push_back('{32'h10220002, 32'h3008, 5, 5, 32'h3010, 2'd0, 0, 1, 32'h0, 32'h0, 0});
    vq.push_back('{32'h10220002, 32'h3008, 5, 5, 32'h3010, 2'd0, 0, 1, 32'h0, 32'h0, 0});
    vq.push_back('{32'h10220002, 32'h3008, 5, 5, 32'h3010, 2'd1, 1, 0, 32'h10220002, 32'h300C, 1});
    vq.push_back('{32'h00221821, 32'h300C, 1, 2, 32'h0, 2'd0, 0, 0, 32'h00221821, 32'h3010, 1});
    vq.push_back('{32'h00632021, 32'h3010, 3, 3, 32'h0, 2'd0, 0, 0, 32'h00632021, 32'h3014, 1});
    vq.push_back('{32'h10800003, 32'h3014, 1, 2, 32'h3020, 2'd0, 0, 1, 32'h0, 32'h0, 0});
    vq.push_back('{32'h10800003, 32'h3014, 1, 2, 32'h3020, 2'd0, 0, 0, 32'h10800003, 32'h3018, 1});
    vq.push_back('{32'h14220004, 32'h3018, 7, 8, 32'h3028, 2'd1, 1, 0, 32'h14220004, 32'h301C, 1});
    vq.push_back('{32'h1022FFFF, 32'h3004, 5, 5, 32'h3000, 2'd1, 1, 0, 32'h1022FFFF, 32'h3008, 1});
    vq.push_back('{32'h0C000C01, 32'h3008, 0, 0, 32'h3004, 2'd1, 0, 0, 32'h0C000C01, 32'h300C, 1});
    vq.push_back('{32'h03E00008, 32'h3004, 32'h300C, 0, 32'h0, 2'd2, 0, 0, 32'h03E00008, 32'h3008, 1});
    vq.push_back('{32'h08000100, 32'h40000010, 0, 0, 32'h40000400, 2'd1, 0, 0, 32'h08000100, 32'h40000014, 1});
    vq.push_back('{32'h00A00008, 32'h3000, 32'h3010, 0, 32'h0, 2'd2, 0, 0, 32'h00A00008, 32'h3004, 1});
    vq.push_back('{32'h34051234, 32'h3100, 0, 0, 32'h0, 2'd0, 0, 0, 32'h34051234, 32'h3104, 1});
    vq.push_back('{32'h8C070000, 32'h3104, 0, 0, 32'h0, 2'd0, 0, 0, 32'h8C070000, 32'h3108, 1});
    vq.push_back('{32'hAC070000, 32'h3108, 0, 0, 32'h0, 2'd0, 0, 0, 32'hAC070000, 32'h310C, 1});
    vq.push_back('{32'h00E04021, 32'h310C, 0, 0, 32'h0, 2'd0, 0, 0, 32'h00E04021, 32'h3110, 1});
    vq.push_back('{32'h8C090000, 32'h3110, 0, 0, 32'h0, 2'd0, 0, 0, 32'h8C090000, 32'h3114, 1});
    vq.push_back('{32'h00095021, 32'h3114, 0, 0, 32'h0, 2'd0, 0, 1, 32'h0, 32'h0, 0});
    vq.push_back('{32'h00095021, 32'h3114, 0, 0, 32'h0, 2'd0, 0, 0, 32'h00095021, 32'h3118, 1});
    vq.push_back('{32'hFC210000, 32'h3118, 0, 0, 32'h0, 2'd0, 0, 0, 32'hFC210000, 32'h311C, 1});
    vq.push_back('{32'h8C000000, 32'h311C, 0, 0, 32'h0, 2'd0, 0, 0, 32'h8C000000, 32'h3120, 1});
    vq.push_back('{32'h10000001, 32'h3200, 0, 0, 32'h3204, 2'd1, 1, 0, 32'h10000001, 32'h3204, 1});

    Reset = 1'b1;
    IRD = 32'd0; PC4D = 32'd0; RS_D = 32'd0; RT_D = 32'd0;
    @(posedge Clk); #1;
    chk("reset IRE", IRE, 32'd0);
    chk("reset PC8E", PC8E, 32'd0);
    chk("reset PauseF", 32'(PauseF), 32'd0);
    chk("reset PauseD", 32'(PauseD), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge Clk);
      IRD = vq[i].ird; PC4D = vq[i].pc4d; RS_D = vq[i].rs; RT_D = vq[i].rt;
      #1;
      chk($sformatf("v%0d NPC", i), NPC, vq[i].npc);
      chk($sformatf("v%0d PCsrc", i), 32'(PCsrc), 32'(vq[i].pcsrc));
      chk($sformatf("v%0d Branch", i), 32'(Branch), 32'(vq[i].br));
      chk($sformatf("v%0d PauseF", i), 32'(PauseF), 32'(vq[i].pause));
      chk($sformatf("v%0d PauseD", i), 32'(PauseD), 32'(vq[i].pause));
      chk($sformatf("v%0d RS_D_OUT", i), RS_D_OUT, vq[i].rs);
      @(posedge Clk); #1;
      chk($sformatf("v%0d IRE", i), IRE, vq[i].ire);
      if (vq[i].chk_pc8e) chk($sformatf("v%0d PC8E", i), PC8E, vq[i].pc8e);
    end

    // Reset pulse in the middle of a lw-use stall
    @(negedge Clk);
    IRD = 32'h8C010000; PC4D = 32'h5000; RS_D = 32'd5; RT_D = 32'd5;
    @(negedge Clk);
    IRD = 32'h10220002; PC4D = 32'h5004;
    #1;
    chk("rst pre PauseF", 32'(PauseF), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("rst mid IRE", IRE, 32'd0);
    chk("rst mid PC8E", PC8E, 32'd0);
    chk("rst mid PauseF", 32'(PauseF), 32'd0);
    chk("rst mid PauseD", 32'(PauseD), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst post PauseF", 32'(PauseF), 32'd0);
    chk("rst post PCsrc", 32'(PCsrc), 32'd1);
    chk("rst post NPC", NPC, 32'h500C);
    @(posedge Clk); #1;
    chk("rst post IRE", IRE, 32'h10220002);

    // mult followed by mflo
    @(negedge Clk);
    IRD = 32'h00220018; PC4D = 32'h6000; RS_D = 32'd0; RT_D = 32'd0;
    #1;
    chk("md mult PauseF", 32'(PauseF), 32'd0);
    @(negedge Clk);
    IRD = 32'h00003012; PC4D = 32'h6004;
    #1;
    stalls = 0;
    while (PauseF && stalls < 20) begin
      chk($sformatf("md stall%0d IRE", stalls), IRE, (stalls == 0) ? 32'h00220018 : 32'd0);
      stalls++;
      @(negedge Clk); #1;
    end
    chk("md stall count", 32'(stalls), 32'(EXP_MD_STALLS));
    chk("md PauseD", 32'(PauseD), 32'd0);
    @(posedge Clk); #1;
    chk("md mflo IRE", IRE, 32'h00003012);
    chk("md mflo PC8E", PC8E, 32'h6008);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
